frequency_meter: RTL and testbench

- Measures the rate of an external, asynchronous square-wave input by counting its rising edges over a fixed gate window of clkin cycles.
- Complements the team's clock dividers: it checks their outputs, or any slow off-board signal, on the board.
- Result can drive the seven-segment/LED display path.
- Single-shot or continuous operation.

---
 rtl/freq_meter_pkg.sv | 28 ++
 rtl/sync_edge_detect.sv | 27 ++
 rtl/frequency_meter.sv | 109 ++++++++++
 tb/tb_frequency_meter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: FSM encoding, default sizing
// and the width helper used to size the gate timer.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_GATE_CYCLES = 50000000;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_SYNC_STAGES = 2;

  // Bits needed to hold the values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer followed by a history flop; rise pulses for one
// cycle on each synchronized low-to-high transition of async_in.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clkin,
  input  logic clr,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clkin or posedge clr) begin
    if (clr) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/frequency_meter.sv
// Counts synchronized rising edges of sig_in over a fixed gate of
// GATE_CYCLES clkin cycles, single-shot (start) or back-to-back (cont).
module frequency_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clkin,
  input  logic             clr,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic [CNT_W-1:0] freq_count,
  output logic             valid,
  output logic             busy,
  output logic             overflow
);

  localparam int               TMR_W    = clog2(GATE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] edge_cnt;
  logic             sat;
  logic             rise;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_nxt;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clkin    (clkin),
    .clr      (clr),
    .async_in (sig_in),
    .rise     (rise)
  );

  // Saturating count including this cycle's edge, so the last gate cycle counts.
  always_comb begin
    cnt_nxt = edge_cnt;
    sat_nxt = sat;
    if (rise) begin
      if (edge_cnt == CNT_MAX) sat_nxt = 1'b1;
      else                     cnt_nxt = edge_cnt + 1'b1;
    end
  end

  // valid is a one-cycle strobe with no back-pressure: freq_count and
  // overflow change only together with it and then hold until the next one.
  always_ff @(posedge clkin or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      timer      <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
      freq_count <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (start || cont) begin
            state    <= GATE;
            busy     <= 1'b1;
            timer    <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
          end
        end
        GATE: begin
          edge_cnt <= cnt_nxt;
          sat      <= sat_nxt;
          timer    <= timer + 1'b1;
          if (timer == TMR_LAST) begin
            state      <= DONE;
            busy       <= 1'b0;
            valid      <= 1'b1;
            freq_count <= cnt_nxt;
            overflow   <= sat_nxt;
          end
        end
        DONE: begin
          valid <= 1'b0;
          if (cont) begin
            state    <= GATE;
            busy     <= 1'b1;
            timer    <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frequency_meter.sv
// Randomized bench for frequency_meter: two instances (8-bit and 4-bit result)
// share stimulus; expected counts come from a list of driven sig_in rises.
module tb_frequency_meter;

  localparam int GC   = 100;
  localparam int SYNC = 2;

  typedef struct {
    int cyc;
    int cnt;
    bit ovf;
  } rec_t;

  logic       clk = 1'b0;
  logic       clr, sig_in, start, cont;
  logic [7:0] freq8;
  logic       valid8, busy8, ovf8;
  logic [3:0] freq4;
  logic       valid4, busy4, ovf4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int busy_cnt;
  int gen_half, gen_cnt;
  bit gen_on;
  int         rise_q[$];
  logic [7:0] exp_q[$];
  rec_t       v8_q[$];
  rec_t       v4_q[$];

  frequency_meter #(.GATE_CYCLES(GC), .CNT_W(8), .SYNC_STAGES(SYNC)) dut8 (
    .clkin(clk), .clr(clr), .sig_in(sig_in), .start(start), .cont(cont),
    .freq_count(freq8), .valid(valid8), .busy(busy8), .overflow(ovf8)
  );

  frequency_meter #(.GATE_CYCLES(GC), .CNT_W(4), .SYNC_STAGES(SYNC)) dut4 (
    .clkin(clk), .clr(clr), .sig_in(sig_in), .start(start), .cont(cont),
    .freq_count(freq4), .valid(valid4), .busy(busy4), .overflow(ovf4)
  );

  // Clock/reset block and output monitor
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid8) v8_q.push_back('{cyc, int'(freq8), ovf8});
    if (valid4) v4_q.push_back('{cyc, int'(freq4), ovf4});
    if (busy8) busy_cnt++;
  end

  // Reference: a rise driven after edge c is seen SYNC+1 edges later; a gate
  // opened at edge g counts what is seen at edges g+1 .. g+GC.
  function automatic int model_count(input int g);
    int n = 0;
    foreach (rise_q[i])
      if (rise_q[i] + SYNC + 1 >= g + 1 && rise_q[i] + SYNC + 1 <= g + GC) n++;
    return n;
  endfunction

  function automatic int sat_val(input int n, input int w);
    int mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  // Driver tasks
  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (gen_on) begin
        if (gen_cnt >= gen_half - 1) begin
          gen_cnt = 0;
          sig_in  = ~sig_in;
          if (sig_in) rise_q.push_back(cyc);
        end else begin
          gen_cnt++;
        end
      end
    end
  endtask

  task automatic pulse_start(output int g);
    start = 1'b1;
    g     = cyc + 1;
    run_cycles(1);
    start = 1'b0;
  endtask

  task automatic quiesce();
    gen_on = 1'b0;
    sig_in = 1'b0;
    run_cycles(6);
    rise_q.delete();
    v8_q.delete();
    v4_q.delete();
    busy_cnt = 0;
  endtask

  task automatic start_gen(input int half);
    gen_half = half;
    gen_cnt  = $urandom_range(0, half - 1);
    gen_on   = 1'b1;
    run_cycles(3);
  endtask

  // Tests
  task automatic test_reset();
    clr = 1'b1; start = 1'b0; cont = 1'b0; sig_in = 1'b0; gen_on = 1'b0;
    run_cycles(3);
    total += 5;
    if (freq8 !== 8'd0) begin bad++; $display("FAIL reset_freq8: got %0d want 0", freq8); end
    if (valid8 !== 1'b0) begin bad++; $display("FAIL reset_valid8: got %b want 0", valid8); end
    if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy8: got %b want 0", busy8); end
    if (ovf8 !== 1'b0) begin bad++; $display("FAIL reset_ovf8: got %b want 0", ovf8); end
    if (freq4 !== 4'd0) begin bad++; $display("FAIL reset_freq4: got %0d want 0", freq4); end
    clr = 1'b0;
    run_cycles(3);
  endtask

  task automatic test_single();
    int g, n;
    quiesce();
    start_gen(5);
    pulse_start(g);
    run_cycles(GC + 15);
    gen_on = 1'b0;
    n = model_count(g);
    total += 1;
    if (v8_q.size() != 1) begin
      bad++; $display("FAIL single_valid_count: got %0d want 1", v8_q.size());
    end else begin
      total += 4;
      if (v8_q[0].cyc != g + GC) begin bad++; $display("FAIL single_latency: got %0d want %0d", v8_q[0].cyc - g + 1, GC + 1); end
      if (v8_q[0].cnt != n) begin bad++; $display("FAIL single_model: got %0d want %0d", v8_q[0].cnt, n); end
      if (v8_q[0].cnt != 10) begin bad++; $display("FAIL single_freq: got %0d want 10", v8_q[0].cnt); end
      if (v8_q[0].ovf !== 1'b0) begin bad++; $display("FAIL single_ovf: got %b want 0", v8_q[0].ovf); end
    end
    total += 2;
    if (busy_cnt != GC) begin bad++; $display("FAIL single_busy_len: got %0d want %0d", busy_cnt, GC); end
    if (busy8 !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", busy8); end
  endtask

  task automatic test_random_periods();
    int g, n, half;
    for (int it = 0; it < 4; it++) begin
      quiesce();
      half = $urandom_range(1, 12);
      start_gen(half);
      pulse_start(g);
      run_cycles(GC + 8);
      gen_on = 1'b0;
      n = model_count(g);
      total += 2;
      if (v8_q.size() != 1 || v4_q.size() != 1) begin
        bad++; $display("FAIL rand_valid_count: got %0d want 1 (half=%0d)", v8_q.size(), half);
      end else begin
        if (v8_q[0].cnt != n || v8_q[0].ovf != (n > 255)) begin
          bad++; $display("FAIL rand_freq8: got %0d/%b want %0d (half=%0d)", v8_q[0].cnt, v8_q[0].ovf, n, half);
        end
        total += 1;
        if (v4_q[0].cnt != sat_val(n, 4) || v4_q[0].ovf != (n > 15)) begin
          bad++; $display("FAIL rand_freq4: got %0d/%b want %0d/%b (half=%0d)", v4_q[0].cnt, v4_q[0].ovf, sat_val(n, 4), n > 15, half);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int g0, sum;
    logic [7:0] e;
    quiesce();
    start_gen(2);
    cont = 1'b1;
    g0   = cyc + 1;
    run_cycles(2 * (GC + 1) + 10);
    cont = 1'b0;
    run_cycles(GC + 20);
    gen_on = 1'b0;
    for (int k = 0; k < 3; k++) exp_q.push_back(8'(model_count(g0 + k * (GC + 1))));
    total += 1;
    if (v8_q.size() != 3) begin
      bad++; $display("FAIL cont_valid_count: got %0d want 3", v8_q.size());
      exp_q.delete();
    end else begin
      sum = 0;
      for (int k = 0; k < 3; k++) begin
        e = exp_q.pop_front();
        sum += v8_q[k].cnt;
        total += 3;
        if (v8_q[k].cyc != g0 + k * (GC + 1) + GC) begin bad++; $display("FAIL cont_timing%0d: got %0d want %0d", k, v8_q[k].cyc, g0 + k * (GC + 1) + GC); end
        if (v8_q[k].cnt != int'(e)) begin bad++; $display("FAIL cont_model%0d: got %0d want %0d", k, v8_q[k].cnt, e); end
        if (v8_q[k].cnt != 25) begin bad++; $display("FAIL cont_freq%0d: got %0d want 25", k, v8_q[k].cnt); end
      end
      total += 1;
      if (sum != 75) begin bad++; $display("FAIL cont_total: got %0d want 75", sum); end
    end
    total += 1;
    if (busy8 !== 1'b0) begin bad++; $display("FAIL cont_stop: got busy %b want 0", busy8); end
  endtask

  task automatic test_overflow();
    int g;
    quiesce();
    start_gen(1);
    pulse_start(g);
    run_cycles(GC + 8);
    total += 1;
    if (v4_q.size() != 1 || v8_q.size() != 1) begin
      bad++; $display("FAIL ovf_valid_count: got %0d want 1", v4_q.size());
    end else begin
      total += 3;
      if (v4_q[0].cnt != 15) begin bad++; $display("FAIL ovf_freq4: got %0d want 15", v4_q[0].cnt); end
      if (v4_q[0].ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag4: got %b want 1", v4_q[0].ovf); end
      if (v8_q[0].cnt != 50 || v8_q[0].ovf !== 1'b0) begin bad++; $display("FAIL ovf_freq8: got %0d/%b want 50/0", v8_q[0].cnt, v8_q[0].ovf); end
    end
    quiesce();
    start_gen(10);
    pulse_start(g);
    run_cycles(GC + 8);
    gen_on = 1'b0;
    total += 1;
    if (v4_q.size() != 1) begin
      bad++; $display("FAIL ovf2_valid_count: got %0d want 1", v4_q.size());
    end else begin
      total += 2;
      if (v4_q[0].cnt != 5) begin bad++; $display("FAIL ovf2_freq4: got %0d want 5", v4_q[0].cnt); end
      if (v4_q[0].ovf !== 1'b0) begin bad++; $display("FAIL ovf2_flag4: got %b want 0", v4_q[0].ovf); end
    end
  endtask

  task automatic test_final_edge();
    int g, c, want;
    for (int d = 0; d < 2; d++) begin
      quiesce();
      pulse_start(g);
      c = g + GC - SYNC - 1 + d;
      run_cycles(c - cyc);
      sig_in = 1'b1;
      rise_q.push_back(cyc);
      run_cycles(4);
      sig_in = 1'b0;
      run_cycles(10);
      want = (d == 0) ? 1 : 0;
      total += 1;
      if (v8_q.size() != 1) begin
        bad++; $display("FAIL edge%0d_valid_count: got %0d want 1", d, v8_q.size());
      end else begin
        total += 2;
        if (v8_q[0].cnt != model_count(g)) begin bad++; $display("FAIL edge%0d_model: got %0d want %0d", d, v8_q[0].cnt, model_count(g)); end
        if (v8_q[0].cnt != want) begin bad++; $display("FAIL edge%0d_freq: got %0d want %0d", d, v8_q[0].cnt, want); end
      end
    end
  endtask

  task automatic test_clr_abort();
    int g, n;
    quiesce();
    start_gen(5);
    pulse_start(g);
    run_cycles(50);
    clr = 1'b1;
    #1;
    total += 4;
    if (busy8 !== 1'b0) begin bad++; $display("FAIL clr_busy: got %b want 0", busy8); end
    if (freq8 !== 8'd0) begin bad++; $display("FAIL clr_freq8: got %0d want 0", freq8); end
    if (valid8 !== 1'b0 || ovf8 !== 1'b0) begin bad++; $display("FAIL clr_flags: got %b%b want 00", valid8, ovf8); end
    if (freq4 !== 4'd0 || ovf4 !== 1'b0) begin bad++; $display("FAIL clr_out4: got %0d/%b want 0/0", freq4, ovf4); end
    run_cycles(2);
    clr = 1'b0;
    run_cycles(GC);
    total += 1;
    if (v8_q.size() != 0) begin bad++; $display("FAIL clr_no_valid: got %0d want 0", v8_q.size()); end
    pulse_start(g);
    run_cycles(GC + 8);
    gen_on = 1'b0;
    n = model_count(g);
    total += 1;
    if (v8_q.size() != 1) begin
      bad++; $display("FAIL clr_restart_count: got %0d want 1", v8_q.size());
    end else begin
      total += 2;
      if (v8_q[0].cyc != g + GC) begin bad++; $display("FAIL clr_restart_time: got %0d want %0d", v8_q[0].cyc, g + GC); end
      if (v8_q[0].cnt != n || n != 10) begin bad++; $display("FAIL clr_restart_freq: got %0d want %0d", v8_q[0].cnt, n); end
    end
  endtask

  task automatic test_start_ignored();
    int g;
    quiesce();
    sig_in = 1'b1;
    rise_q.push_back(cyc);
    run_cycles(10);
    pulse_start(g);
    run_cycles(30);
    start = 1'b1;
    run_cycles(1);
    start = 1'b0;
    run_cycles(GC);
    total += 1;
    if (v8_q.size() != 1) begin
      bad++; $display("FAIL ign_valid_count: got %0d want 1", v8_q.size());
    end else begin
      total += 2;
      if (v8_q[0].cyc != g + GC) begin bad++; $display("FAIL ign_time: got %0d want %0d", v8_q[0].cyc, g + GC); end
      if (v8_q[0].cnt != model_count(g)) begin bad++; $display("FAIL ign_freq: got %0d want %0d", v8_q[0].cnt, model_count(g)); end
    end
    total += 1;
    if (busy8 !== 1'b0) begin bad++; $display("FAIL ign_idle: got %b want 0", busy8); end
    sig_in = 1'b0;
  endtask

  initial begin
    busy_cnt = 0;
    gen_half = 1;
    gen_cnt  = 0;
    gen_on   = 1'b0;
    test_reset();
    test_single();
    test_random_periods();
    test_back_to_back();
    test_overflow();
    test_final_edge();
    test_clr_abort();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
